// File: rtl/ysyx_040750_opfetch_if.sv
// Operand-fetch bus bundle: decode-side request, register-file read port,
// EX/MEM/WB bypass sources, flush, and the ID/EX output handshake and payload.
// Latency/backpressure: none here; the slave modport is the stage, the master modport is its environment.
interface ysyx_040750_opfetch_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             I_in_valid;
    logic             O_in_ready;
    logic [XLEN-1:0]  I_pc;
    logic [4:0]       I_rs1_addr;
    logic [4:0]       I_rs2_addr;
    logic [4:0]       I_rd_addr;
    logic             I_rd_wen;
    logic [4:0]       O_gpr_rs1_addr;
    logic [4:0]       O_gpr_rs2_addr;
    logic [XLEN-1:0]  I_gpr_rs1_data;
    logic [XLEN-1:0]  I_gpr_rs2_data;
    logic             I_ex_wen;
    logic [4:0]       I_ex_rd;
    logic [XLEN-1:0]  I_ex_data;
    logic             I_ex_data_ok;
    logic             I_mem_wen;
    logic [4:0]       I_mem_rd;
    logic [XLEN-1:0]  I_mem_data;
    logic             I_mem_data_ok;
    logic             I_wb_wen;
    logic [4:0]       I_wb_rd;
    logic [XLEN-1:0]  I_wb_data;
    logic             I_flush;
    logic             O_out_valid;
    logic             I_out_ready;
    logic [XLEN-1:0]  O_pc;
    logic [4:0]       O_rd_addr;
    logic             O_rd_wen;
    logic [XLEN-1:0]  O_rs1_data;
    logic [XLEN-1:0]  O_rs2_data;
    logic [CNT_W-1:0] O_stall_cnt;

    modport slave (
        input  I_in_valid, I_pc, I_rs1_addr, I_rs2_addr, I_rd_addr, I_rd_wen,
        input  I_gpr_rs1_data, I_gpr_rs2_data,
        input  I_ex_wen, I_ex_rd, I_ex_data, I_ex_data_ok,
        input  I_mem_wen, I_mem_rd, I_mem_data, I_mem_data_ok,
        input  I_wb_wen, I_wb_rd, I_wb_data,
        input  I_flush, I_out_ready,
        output O_in_ready, O_gpr_rs1_addr, O_gpr_rs2_addr,
        output O_out_valid, O_pc, O_rd_addr, O_rd_wen, O_rs1_data, O_rs2_data,
        output O_stall_cnt
    );

    modport master (
        output I_in_valid, I_pc, I_rs1_addr, I_rs2_addr, I_rd_addr, I_rd_wen,
        output I_gpr_rs1_data, I_gpr_rs2_data,
        output I_ex_wen, I_ex_rd, I_ex_data, I_ex_data_ok,
        output I_mem_wen, I_mem_rd, I_mem_data, I_mem_data_ok,
        output I_wb_wen, I_wb_rd, I_wb_data,
        output I_flush, I_out_ready,
        input  O_in_ready, O_gpr_rs1_addr, O_gpr_rs2_addr,
        input  O_out_valid, O_pc, O_rd_addr, O_rd_wen, O_rs1_data, O_rs2_data,
        input  O_stall_cnt
    );
endinterface

// File: rtl/ysyx_040750_opfetch.sv
// Operand fetch: reads GPRs, bypasses EX/MEM/WB results, stalls on unready producers, feeds a 1-entry ID/EX register.
// Latency: 1 cycle (accept at edge N, payload visible after N); 1 instr/cycle when hazard-free.
// Backpressure: O_in_ready drops on hazard, flush, or a full register that EX is not draining.
// Ports: I_sys_clk/I_rst plain; everything else on bus (slave modport of ysyx_040750_opfetch_if).
module ysyx_040750_opfetch #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic                   I_sys_clk,
    input  logic                   I_rst,
    ysyx_040750_opfetch_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } payload_t;

    state_t           state_q, state_d;
    payload_t         pay_q, pay_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  op1, op2;
    logic             hz1, hz2;
    logic             hazard, in_ready, accept;

    // A producer writing x0 never forwards.
    function automatic logic hit(input logic wen, input logic [4:0] rd, input logic [4:0] a);
        return wen && (rd != 5'd0) && (rd == a);
    endfunction

    assign bus.O_gpr_rs1_addr = bus.I_rs1_addr;
    assign bus.O_gpr_rs2_addr = bus.I_rs2_addr;

    // Youngest producer wins; if it is not ready the source stalls even when an
    // older stage holds a ready value for the same register. WB is bypassed
    // because the register file writes on the same edge and reads stale data.
    always_comb begin
        op1 = '0;
        hz1 = 1'b0;
        if (bus.I_rs1_addr == 5'd0) begin
            op1 = '0;
        end else if (hit(bus.I_ex_wen, bus.I_ex_rd, bus.I_rs1_addr)) begin
            op1 = bus.I_ex_data;
            hz1 = !bus.I_ex_data_ok;
        end else if (hit(bus.I_mem_wen, bus.I_mem_rd, bus.I_rs1_addr)) begin
            op1 = bus.I_mem_data;
            hz1 = !bus.I_mem_data_ok;
        end else if (hit(bus.I_wb_wen, bus.I_wb_rd, bus.I_rs1_addr)) begin
            op1 = bus.I_wb_data;
        end else begin
            op1 = bus.I_gpr_rs1_data;
        end
    end

    always_comb begin
        op2 = '0;
        hz2 = 1'b0;
        if (bus.I_rs2_addr == 5'd0) begin
            op2 = '0;
        end else if (hit(bus.I_ex_wen, bus.I_ex_rd, bus.I_rs2_addr)) begin
            op2 = bus.I_ex_data;
            hz2 = !bus.I_ex_data_ok;
        end else if (hit(bus.I_mem_wen, bus.I_mem_rd, bus.I_rs2_addr)) begin
            op2 = bus.I_mem_data;
            hz2 = !bus.I_mem_data_ok;
        end else if (hit(bus.I_wb_wen, bus.I_wb_rd, bus.I_rs2_addr)) begin
            op2 = bus.I_wb_data;
        end else begin
            op2 = bus.I_gpr_rs2_data;
        end
    end

    assign hazard   = bus.I_in_valid && (hz1 || hz2);
    assign in_ready = !bus.I_flush && !hazard && ((state_q == EMPTY) || bus.I_out_ready);
    assign accept   = bus.I_in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        pay_d   = pay_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (bus.I_flush)          state_d = EMPTY;
                else if (accept)          state_d = FULL;
                else if (bus.I_out_ready) state_d = EMPTY;
                else                      state_d = FULL;
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            pay_d.pc     = bus.I_pc;
            pay_d.rd     = bus.I_rd_addr;
            pay_d.rd_wen = bus.I_rd_wen;
            pay_d.rs1    = op1;
            pay_d.rs2    = op2;
        end
        // Saturating stall counter: holds at all-ones.
        if (hazard && !bus.I_flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q <= EMPTY;
            pay_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.O_in_ready  = in_ready;
    assign bus.O_out_valid = (state_q == FULL);
    assign bus.O_pc        = pay_q.pc;
    assign bus.O_rd_addr   = pay_q.rd;
    assign bus.O_rd_wen    = pay_q.rd_wen;
    assign bus.O_rs1_data  = pay_q.rs1;
    assign bus.O_rs2_data  = pay_q.rs2;
    assign bus.O_stall_cnt = cnt_q;
endmodule
